// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
// Module   : iter_divider
// Purpose  : Multi-cycle restoring shift-subtract integer divider producing
//            quotient and remainder, one quotient bit per clock, with a
//            start/done handshake.
//            Optional signed support (abs-value in, sign fix-up out, and
//            most-negative / -1 overflow handling) is compiled in when the
//            macro ITER_DIVIDER_SIGNED_EN is defined; otherwise signed_op is
//            ignored and every operation is unsigned.
// Revision : 1.0 - initial release
// ============================================================================
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int            c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    // r_dq starts as the dividend magnitude and fills with quotient bits
    // from the LSB as dividend bits leave through the MSB.
    logic [WIDTH-1:0]   r_dq;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_div;
    logic [c_cnt_w-1:0] r_cnt;

    logic               r_done;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;

    logic               w_accept;
    logic               w_div0;
    logic               w_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    // One-bit-wider partial remainder so the compare never wraps even when
    // the divisor has its MSB set.
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_nxt;

    assign w_div0    = (b == '0);
    assign w_special = w_div0 | w_ovf;

`ifdef ITER_DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

    logic w_a_neg;
    logic w_b_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_neg = signed_op & a[WIDTH-1];
    assign w_b_neg = signed_op & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;
    assign w_ovf   = signed_op && (a == c_min_neg) && (b == '1);
    assign w_q_fix = r_neg_q ? -r_dq : r_dq;
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;

    // Sign fix-up flags; special-case results are loaded final, so no fix-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= !w_special && (w_a_neg ^ w_b_neg);
            r_neg_r <= !w_special && w_a_neg;
        end
    end
`else
    logic w_unused_signed_op;

    assign w_unused_signed_op = signed_op;
    assign w_a_mag = a;
    assign w_b_mag = b;
    assign w_ovf   = 1'b0;
    assign w_q_fix = r_dq;
    assign w_r_fix = r_rem;
`endif

    assign w_trial   = {r_rem, r_dq[WIDTH-1]};
    assign w_diff    = w_trial - {1'b0, r_div};
    assign w_qbit    = ~w_diff[WIDTH];
    assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: specials skip RUN; RUN ends after WIDTH iterations.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? c_st_done : c_st_run;
                end
            end
            c_st_run: begin
                if (r_cnt == c_cnt_one) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // FSM outputs; a start seen during the done pulse is dropped because the
    // previous result is still being presented.
    always_comb begin
        busy     = (r_state == c_st_run) || (r_state == c_st_done);
        w_accept = (r_state == c_st_idle) && start && !r_done;
    end

    // Operand capture and one restoring shift-subtract step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dq  <= '0;
            r_rem <= '0;
            r_div <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_div <= w_b_mag;
            r_cnt <= c_cnt_load;
            if (w_div0) begin
                r_dq  <= '1;
                r_rem <= a;
            end else if (w_ovf) begin
                r_dq  <= a;
                r_rem <= '0;
            end else begin
                r_dq  <= w_a_mag;
                r_rem <= '0;
            end
        end else if (r_state == c_st_run) begin
            r_dq  <= {r_dq[WIDTH-2:0], w_qbit};
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt - c_cnt_one;
        end
    end

    // Result registers: updated only when leaving DONE, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_q    <= '0;
            r_r    <= '0;
        end else if (r_state == c_st_done) begin
            r_done <= 1'b1;
            r_q    <= w_q_fix;
            r_r    <= w_r_fix;
        end else begin
            r_done <= 1'b0;
        end
    end

    assign done = r_done;
    assign q    = r_q;
    assign r    = r_r;

endmodule
`default_nettype wire

// File: tb/tb_iter_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_divider
// Purpose  : Directed self-checking bench for iter_divider (WIDTH=32).
//            Expected values follow ITER_DIVIDER_SIGNED_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iter_divider;

    localparam int W = 32;
    localparam int LAT_NORM = W + 1;   // edges after the start edge until done
    localparam int LAT_SPEC = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         signed_op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses;

    always #5 clk = ~clk;

    iter_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .r         (r)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called at the negedge right after the start edge; counts edges to done.
    task automatic wait_done(input string tag, input int exp_lat);
        int k = 0;
        while (done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, W'(k), W'(exp_lat));
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic sop, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input int lat);
        @(negedge clk);
        a = ta; b = tb; signed_op = sop; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check1({tag, " busy after start"}, busy, 1'b1);
        wait_done(tag, lat);
        check({tag, " q"}, q, eq);
        check({tag, " r"}, r, er);
        check1({tag, " busy in done cycle"}, busy, 1'b0);
        @(negedge clk);
        check1({tag, " done one cycle"}, done, 1'b0);
        check({tag, " q held"}, q, eq);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check1("reset busy", busy, 1'b0);
        check1("reset done", done, 1'b0);
        check("reset q", q, '0);
        check("reset r", r, '0);
        rst_n = 1'b1;

        do_op("u100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, LAT_NORM);
        do_op("div0", 32'd12345, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd12345, LAT_SPEC);
        do_op("a<b", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, LAT_NORM);
        do_op("big divisor", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE, LAT_NORM);
        do_op("s div0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, LAT_SPEC);
`ifdef ITER_DIVIDER_SIGNED_EN
        do_op("s -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT_NORM);
        do_op("s 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, LAT_NORM);
        do_op("s -100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, LAT_NORM);
        do_op("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, LAT_SPEC);
`else
        do_op("s -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, LAT_NORM);
        do_op("s 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, LAT_NORM);
        do_op("s -100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd0, 32'hFFFF_FF9C, LAT_NORM);
        do_op("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, LAT_NORM);
`endif

        // start held for 40 cycles; operands change mid-run and must be ignored
        @(negedge clk);
        a = 32'd50; b = 32'd5; signed_op = 1'b0; start = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) check1("hold busy", busy, 1'b1);
            if (k == 10) begin
                a = 32'd9; b = 32'd3;
            end
            if (done === 1'b1) begin
                pulses++;
                check("hold latency", W'(k), W'(LAT_NORM));
                check("hold q", q, 32'd10);
                check("hold r", r, 32'd0);
            end
            if (k == 34) check1("start in done cycle ignored", busy, 1'b0);
            if (k == 35) check1("second op accepted", busy, 1'b1);
        end
        start = 1'b0;
        check("hold pulses", W'(pulses), 32'd1);
        wait_done("second op", LAT_NORM - 4);
        check("second op q", q, 32'd3);
        check("second op r", r, 32'd0);

        // asynchronous abort mid-run
        @(negedge clk);
        a = 32'd1000; b = 32'd3; signed_op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check1("abort busy", busy, 1'b0);
        check1("abort done", done, 1'b0);
        check("abort q", q, '0);
        check("abort r", r, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("abort no done", W'(pulses), 32'd0);
        check1("abort idle", busy, 1'b0);

        do_op("after abort", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, LAT_NORM);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
